// File: rtl/xlr8_ioarb_pkg.sv
// Shared types and widths for the AVR I/O bus arbiter.
package xlr8_ioarb_pkg;

  typedef enum logic [1:0] {IOARB_IDLE, IOARB_PEND, IOARB_DONE} ioarb_state_t;

  localparam int IOARB_ADR_W = 6;
  localparam int IOARB_DAT_W = 8;

endpackage

// File: rtl/xlr8_ioarb_starve.sv
// Starvation guard: counts CPU-blocked PEND cycles and raises cpu_stall
// until the pending secondary access has completed.
module xlr8_ioarb_starve #(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clken_i,
  input  logic pend_i,
  input  logic cpu_act_i,
  input  logic leave_pend_i,
  input  logic done_exit_i,
  output logic cpu_stall_o
);

  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;
  logic       stall_q, stall_d;

  // Blocked-cycle counter and sticky stall request
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (clken_i && pend_i) begin
      if (leave_pend_i) begin
        cnt_d = 8'h00;
      end else if (cpu_act_i && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'h01;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    // Stall is set on the edge that completes the LIMIT-th blocked cycle.
    if (done_exit_i) begin
      stall_d = 1'b0;
    end else if (cnt_d == LIMIT_C) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Counter and stall registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= 8'h00;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign cpu_stall_o = stall_q;

endmodule

// File: rtl/xlr8_ioarb.sv
// CPU-priority arbiter for the AVR I/O register bus with one secondary requester.
// Optional starvation guard enabled by defining XLR8_IOARB_STARVE_EN.
module xlr8_ioarb
  import xlr8_ioarb_pkg::*;
#(
  parameter int unsigned           STARVE_LIMIT   = 16,
  parameter logic [IOARB_DAT_W-1:0] SEC_RD_DEFAULT = 8'h00
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clken,
  input  logic [IOARB_ADR_W-1:0] adr,
  input  logic [IOARB_DAT_W-1:0] dbus_in,
  input  logic                   iore,
  input  logic                   iowe,
  input  logic                   sec_req,
  input  logic                   sec_we,
  input  logic [IOARB_ADR_W-1:0] sec_adr,
  input  logic [IOARB_DAT_W-1:0] sec_wdata,
  output logic                   sec_ack,
  output logic [IOARB_DAT_W-1:0] sec_rdata,
  output logic [IOARB_ADR_W-1:0] out_adr,
  output logic [IOARB_DAT_W-1:0] out_dbus,
  output logic                   out_iore,
  output logic                   out_iowe,
  input  logic [IOARB_DAT_W-1:0] periph_dbus,
  input  logic                   periph_io_out_en,
  output logic                   cpu_stall
);

  ioarb_state_t           state_q, state_d;
  logic                   we_q, we_d;
  logic [IOARB_ADR_W-1:0] adr_q, adr_d;
  logic [IOARB_DAT_W-1:0] wdata_q, wdata_d;
  logic                   ack_q, ack_d;
  logic [IOARB_DAT_W-1:0] rdata_q, rdata_d;
  logic                   cpu_act_s;
  logic                   sec_issue_s;
  logic                   done_exit_s;

  assign cpu_act_s = iore | iowe;

  // Next-state, request latch and read-data capture
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    sec_issue_s = 1'b0;
    done_exit_s = 1'b0;
    case (state_q)
      IOARB_IDLE: begin
        if (clken && sec_req) begin
          we_d    = sec_we;
          adr_d   = sec_adr;
          wdata_d = sec_wdata;
          state_d = IOARB_PEND;
        end else begin
          state_d = IOARB_IDLE;
        end
      end
      IOARB_PEND: begin
        if (clken && !cpu_act_s) begin
          sec_issue_s = 1'b1;
          ack_d       = 1'b1;
          state_d     = IOARB_DONE;
          if (!we_q) begin
            rdata_d = periph_io_out_en ? periph_dbus : SEC_RD_DEFAULT;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = IOARB_PEND;
        end
      end
      IOARB_DONE: begin
        if (clken) begin
          done_exit_s = 1'b1;
          state_d     = IOARB_IDLE;
        end else begin
          state_d = IOARB_DONE;
        end
      end
      default: state_d = IOARB_IDLE;
    endcase
  end

  // FSM and latched request registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IOARB_IDLE;
      we_q    <= 1'b0;
      adr_q   <= 6'h00;
      wdata_q <= 8'h00;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus mux: CPU wins; the secondary strobe exists only in its issue cycle
  always_comb begin
    out_adr  = adr;
    out_dbus = dbus_in;
    out_iore = 1'b0;
    out_iowe = 1'b0;
    if (cpu_act_s) begin
      out_iore = iore;
      out_iowe = iowe;
    end else if (sec_issue_s) begin
      out_adr  = adr_q;
      out_dbus = wdata_q;
      out_iore = ~we_q;
      out_iowe = we_q;
    end else begin
      out_iore = 1'b0;
      out_iowe = 1'b0;
    end
  end

  assign sec_ack   = ack_q;
  assign sec_rdata = rdata_q;

`ifdef XLR8_IOARB_STARVE_EN
  xlr8_ioarb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .rstn        (rstn),
    .clken_i     (clken),
    .pend_i      (state_q == IOARB_PEND),
    .cpu_act_i   (cpu_act_s),
    .leave_pend_i(sec_issue_s),
    .done_exit_i (done_exit_s),
    .cpu_stall_o (cpu_stall)
  );
`else
  logic [8:0] starve_unused_s;
  assign starve_unused_s = {done_exit_s, 8'(STARVE_LIMIT)};
  assign cpu_stall       = 1'b0;
`endif

endmodule
